// File: rtl/encoder_pkg.sv
// Shared widths, index constants and helpers for the 4-to-2 priority encoder.
// Optional multi-hot detection is enabled with ENCODER_MULTIHOT_DETECT_EN.
package encoder_pkg;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned OUT_W = 2;

    localparam logic [OUT_W-1:0] IDX0 = 2'd0;
    localparam logic [OUT_W-1:0] IDX1 = 2'd1;
    localparam logic [OUT_W-1:0] IDX2 = 2'd2;
    localparam logic [OUT_W-1:0] IDX3 = 2'd3;

    // True when two or more request bits are set.
    function automatic logic is_multi_hot(logic [IN_W-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/encoder_4to2_core.sv
// Combinational priority-encode of the request vector into index, valid and
// (with ENCODER_MULTIHOT_DETECT_EN) a multi-hot flag.
module encoder_4to2_core
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_MSB = 1'b1
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] next_out,
`ifdef ENCODER_MULTIHOT_DETECT_EN
    output logic             next_multi,
`endif
    output logic             next_valid
);

    always_comb begin
        next_out = IDX0;
        if (PRIORITY_MSB) begin
            if (in[3])      next_out = IDX3;
            else if (in[2]) next_out = IDX2;
            else if (in[1]) next_out = IDX1;
            else            next_out = IDX0;
        end else begin
            if (in[0])      next_out = IDX0;
            else if (in[1]) next_out = IDX1;
            else if (in[2]) next_out = IDX2;
            else if (in[3]) next_out = IDX3;
            else            next_out = IDX0;
        end
    end

    assign next_valid = |in;

`ifdef ENCODER_MULTIHOT_DETECT_EN
    assign next_multi = is_multi_hot(in);
`endif

endmodule

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 priority encoder with sample enable and async reset.
// Define ENCODER_MULTIHOT_DETECT_EN to add multi_hot / multi_hot_sticky outputs.
module encoder_4to2
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_MSB = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
`ifdef ENCODER_MULTIHOT_DETECT_EN
    output logic             multi_hot,
    output logic             multi_hot_sticky,
`endif
    output logic             valid
);

    logic [OUT_W-1:0] next_out;
    logic             next_valid;
`ifdef ENCODER_MULTIHOT_DETECT_EN
    logic             next_multi;
`endif

    encoder_4to2_core #(
        .PRIORITY_MSB(PRIORITY_MSB)
    ) u_core (
        .in        (in),
        .next_out  (next_out),
`ifdef ENCODER_MULTIHOT_DETECT_EN
        .next_multi(next_multi),
`endif
        .next_valid(next_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= IDX0;
            valid <= 1'b0;
        end else if (en) begin
            out   <= next_out;
            valid <= next_valid;
        end
    end

`ifdef ENCODER_MULTIHOT_DETECT_EN
    // Sticky flag only sets on sampled inputs; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_hot        <= 1'b0;
            multi_hot_sticky <= 1'b0;
        end else if (en) begin
            multi_hot <= next_multi;
            if (next_multi) multi_hot_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
// Directed self-checking bench for encoder_4to2; two instances cover both priorities.
// Extra checks run when ENCODER_MULTIHOT_DETECT_EN is defined.
module tb_encoder_4to2;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] in;
    logic [1:0] out_m, out_l;
    logic       valid_m, valid_l;
`ifdef ENCODER_MULTIHOT_DETECT_EN
    logic       multi_m, sticky_m, multi_l, sticky_l;
`endif

    int n_checks = 0;
    int n_errors = 0;

    encoder_4to2 #(
        .PRIORITY_MSB(1'b1)
    ) u_msb (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .in              (in),
        .out             (out_m),
`ifdef ENCODER_MULTIHOT_DETECT_EN
        .multi_hot       (multi_m),
        .multi_hot_sticky(sticky_m),
`endif
        .valid           (valid_m)
    );

    encoder_4to2 #(
        .PRIORITY_MSB(1'b0)
    ) u_lsb (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .in              (in),
        .out             (out_l),
`ifdef ENCODER_MULTIHOT_DETECT_EN
        .multi_hot       (multi_l),
        .multi_hot_sticky(sticky_l),
`endif
        .valid           (valid_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] one_hot;
        rst = 1'b1;
        en  = 1'b0;
        in  = 4'b0000;
        #12;
        check("reset out msb", {2'b0, out_m}, 4'd0);
        check("reset valid msb", {3'b0, valid_m}, 4'd0);
        check("reset out lsb", {2'b0, out_l}, 4'd0);
        check("reset valid lsb", {3'b0, valid_l}, 4'd0);
        step();
        rst = 1'b0;

        // One-hot sweep: both priorities give the set bit's index.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            one_hot = 4'b0001 << i;
            in = one_hot;
            step();
            check($sformatf("onehot msb out %0d", i), {2'b0, out_m}, 4'(i));
            check($sformatf("onehot msb valid %0d", i), {3'b0, valid_m}, 4'd1);
            check($sformatf("onehot lsb out %0d", i), {2'b0, out_l}, 4'(i));
        end

        in = 4'b0000;
        step();
        check("zero out msb", {2'b0, out_m}, 4'd0);
        check("zero valid msb", {3'b0, valid_m}, 4'd0);
        check("zero valid lsb", {3'b0, valid_l}, 4'd0);

        in = 4'b0110;
        step();
        check("0110 out msb", {2'b0, out_m}, 4'd2);
        check("0110 out lsb", {2'b0, out_l}, 4'd1);
        check("0110 valid msb", {3'b0, valid_m}, 4'd1);
        check("0110 valid lsb", {3'b0, valid_l}, 4'd1);
`ifdef ENCODER_MULTIHOT_DETECT_EN
        check("0110 multi", {3'b0, multi_m}, 4'd1);
        check("0110 sticky", {3'b0, sticky_m}, 4'd1);
        in = 4'b0010;
        step();
        check("0010 multi", {3'b0, multi_m}, 4'd0);
        check("0010 sticky", {3'b0, sticky_m}, 4'd1);
        check("0010 sticky lsb", {3'b0, sticky_l}, 4'd1);
`endif

        in = 4'b1001;
        step();
        check("1001 out msb", {2'b0, out_m}, 4'd3);
        check("1001 out lsb", {2'b0, out_l}, 4'd0);
        check("1001 valid lsb", {3'b0, valid_l}, 4'd1);

        // Enable hold across input changes.
        in = 4'b0100;
        step();
        check("load 0100 msb", {2'b0, out_m}, 4'd2);
        en = 1'b0;
        in = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold out msb %0d", i), {2'b0, out_m}, 4'd2);
        end
        in = 4'b0000;
        step();
        check("hold valid on zero", {3'b0, valid_m}, 4'd1);
        in = 4'b0010;
        en = 1'b1;
        step();
        check("reenable out msb", {2'b0, out_m}, 4'd1);

        // Asynchronous reset mid-run, away from any clock edge.
        in = 4'b1000;
        step();
        check("pre-reset out msb", {2'b0, out_m}, 4'd3);
        rst = 1'b1;
        #1;
        check("async reset out msb", {2'b0, out_m}, 4'd0);
        check("async reset valid msb", {3'b0, valid_m}, 4'd0);
`ifdef ENCODER_MULTIHOT_DETECT_EN
        check("async reset multi", {3'b0, multi_m}, 4'd0);
        check("async reset sticky", {3'b0, sticky_m}, 4'd0);
`endif
        #1;
        rst = 1'b0;
        step();
        check("post-reset out msb", {2'b0, out_m}, 4'd3);
        check("post-reset valid msb", {3'b0, valid_m}, 4'd1);
        check("post-reset out lsb", {2'b0, out_l}, 4'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
